// File: rtl/gshare_branch_predictor_pkg.sv
// Shared types and helpers for the gshare branch predictor.
//   branch_taken_history_t : 2-bit saturating direction counter encoding
//   btb_entry_t            : BTB line at the default geometry
//   counter_next()         : saturating counter next-state
package gshare_branch_predictor_pkg;

  localparam int DEFAULT_XLEN                = 32;
  localparam int DEFAULT_BTB_LOG_ENTRIES     = 8;
  localparam int DEFAULT_PHT_LOG_ENTRIES     = 10;
  localparam int DEFAULT_GHR_BITS            = 8;
  localparam int DEFAULT_PC_LOW_BITS_IGNORED = 2;

  localparam int DEFAULT_BTB_TAG_BITS =
    DEFAULT_XLEN - DEFAULT_BTB_LOG_ENTRIES - DEFAULT_PC_LOW_BITS_IGNORED;

  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    WEAK_TAKEN       = 2'b10,
    STRONG_TAKEN     = 2'b11
  } branch_taken_history_t;

  typedef struct packed {
    logic                            valid;
    logic [DEFAULT_BTB_TAG_BITS-1:0] tag;
    logic [DEFAULT_XLEN-1:0]         target;
  } btb_entry_t;

  function automatic branch_taken_history_t counter_next(
    input branch_taken_history_t current,
    input logic                  taken
  );
    branch_taken_history_t result;
    result = current;
    case (current)
      STRONG_NOT_TAKEN: result = taken ? WEAK_NOT_TAKEN : STRONG_NOT_TAKEN;
      WEAK_NOT_TAKEN:   result = taken ? WEAK_TAKEN     : STRONG_NOT_TAKEN;
      WEAK_TAKEN:       result = taken ? STRONG_TAKEN   : WEAK_NOT_TAKEN;
      STRONG_TAKEN:     result = taken ? STRONG_TAKEN   : WEAK_TAKEN;
      default:          result = WEAK_NOT_TAKEN;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/gshare_branch_predictor_pht_counter_table.sv
// Pattern history table: one 2-bit saturating counter per entry.
//   clock, reset       : clock / synchronous active-high reset (read register only)
//   init_write/index   : overwrite one entry with weak not-taken
//   update_write/index : read-modify-write of one counter toward update_taken
//   read_enable/index  : capture one counter into read_counter (1-cycle latency)
// Reads observe the array before any same-edge write (read-before-write).
module pht_counter_table
  import gshare_branch_predictor_pkg::*;
#(
  parameter int LOG_ENTRIES = DEFAULT_PHT_LOG_ENTRIES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   init_write,
  input  logic [LOG_ENTRIES-1:0] init_index,
  input  logic                   update_write,
  input  logic [LOG_ENTRIES-1:0] update_index,
  input  logic                   update_taken,
  input  logic                   read_enable,
  input  logic [LOG_ENTRIES-1:0] read_index,
  output branch_taken_history_t  read_counter
);

  localparam int DEPTH = 1 << LOG_ENTRIES;

  branch_taken_history_t counters [DEPTH];

  // Storage carries no reset; the init sequence in the parent clears it.
  always_ff @(posedge clock) begin
    if (init_write) begin
      counters[init_index] <= WEAK_NOT_TAKEN;
    end else if (update_write) begin
      counters[update_index] <= counter_next(counters[update_index], update_taken);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_counter <= STRONG_NOT_TAKEN;
    end else if (read_enable) begin
      read_counter <= counters[read_index];
    end
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare fetch-stage predictor: tagged BTB plus PC^GHR indexed PHT.
//   clock, reset                 : clock / synchronous active-high reset
//   enable                       : pipeline advance, 0 freezes predictions, GHR and training
//   ready                        : tables cleared, predictions meaningful
//   executing_branch_*           : training from the resolved branch
//   incoming_instruction_pc      : fetch PC, prediction appears one cycle later
//   predicted_jump_target_taken  : BTB hit and PHT counter says taken
//   predicted_jump_target        : BTB target (presented even on a miss)
//   predicted_pht_index          : PHT index used, to be carried down the pipe
//
// state | meaning
// INIT  | clearing one BTB/PHT entry per cycle, predictions forced to 0
// RUN   | predicting and training
module gshare_branch_predictor
  import gshare_branch_predictor_pkg::*;
#(
  parameter int XLEN                = DEFAULT_XLEN,
  parameter int BTB_LOG_ENTRIES     = DEFAULT_BTB_LOG_ENTRIES,
  parameter int PHT_LOG_ENTRIES     = DEFAULT_PHT_LOG_ENTRIES,
  parameter int GHR_BITS            = DEFAULT_GHR_BITS,
  parameter int PC_LOW_BITS_IGNORED = DEFAULT_PC_LOW_BITS_IGNORED
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  output logic                       ready,
  input  logic                       executing_branch_active,
  input  logic [XLEN-1:0]            executing_branch_pc,
  input  logic [XLEN-1:0]            executing_branch_target,
  input  logic                       executing_branch_taken,
  input  logic [PHT_LOG_ENTRIES-1:0] executing_branch_pht_index,
  input  logic [XLEN-1:0]            incoming_instruction_pc,
  output logic                       predicted_jump_target_taken,
  output logic [XLEN-1:0]            predicted_jump_target,
  output logic [PHT_LOG_ENTRIES-1:0] predicted_pht_index
);

  localparam int TAG_BITS  = XLEN - BTB_LOG_ENTRIES - PC_LOW_BITS_IGNORED;
  localparam int INIT_BITS = (BTB_LOG_ENTRIES > PHT_LOG_ENTRIES) ? BTB_LOG_ENTRIES
                                                                  : PHT_LOG_ENTRIES;
  localparam logic [INIT_BITS-1:0] INIT_LAST = '1;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [XLEN-1:0]     target;
  } btb_row_t;

  typedef enum logic {INIT, RUN} state_t;

  state_t                     state_q, state_d;
  logic [INIT_BITS-1:0]       init_count_q, init_count_d;
  logic                       init_write_btb, init_write_pht;
  logic [GHR_BITS-1:0]        ghr_q, ghr_next;
  btb_row_t                   btb [1 << BTB_LOG_ENTRIES];
  btb_row_t                   pred_entry_q;
  logic [TAG_BITS-1:0]        pred_tag_q;
  logic [PHT_LOG_ENTRIES-1:0] pred_pht_index_q;
  branch_taken_history_t      pred_counter;

  logic                       running, advance, do_update;
  logic [BTB_LOG_ENTRIES-1:0] fetch_btb_index, update_btb_index;
  logic [TAG_BITS-1:0]        fetch_tag, update_tag;
  logic [PHT_LOG_ENTRIES-1:0] fetch_pht_index;
  logic                       unused_bits;

  assign running   = (state_q == RUN);
  assign advance   = running && enable && !reset;
  assign do_update = advance && executing_branch_active;

  always_comb begin
    state_d        = state_q;
    init_count_d   = init_count_q;
    init_write_btb = 1'b0;
    init_write_pht = 1'b0;
    case (state_q)
      INIT: begin
        // The counter sweeps the deeper table; the shallower one stops early.
        init_write_btb = (init_count_q >> BTB_LOG_ENTRIES) == '0;
        init_write_pht = (init_count_q >> PHT_LOG_ENTRIES) == '0;
        if (init_count_q == INIT_LAST) begin
          state_d = RUN;
        end else begin
          init_count_d = init_count_q + 1'b1;
        end
      end
      RUN: state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= INIT;
      init_count_q <= '0;
    end else begin
      state_q      <= state_d;
      init_count_q <= init_count_d;
    end
  end

  assign fetch_btb_index  = incoming_instruction_pc[PC_LOW_BITS_IGNORED +: BTB_LOG_ENTRIES];
  assign fetch_tag        = incoming_instruction_pc[XLEN-1 -: TAG_BITS];
  assign fetch_pht_index  = incoming_instruction_pc[PC_LOW_BITS_IGNORED +: PHT_LOG_ENTRIES]
                            ^ PHT_LOG_ENTRIES'(ghr_q);
  assign update_btb_index = executing_branch_pc[PC_LOW_BITS_IGNORED +: BTB_LOG_ENTRIES];
  assign update_tag       = executing_branch_pc[XLEN-1 -: TAG_BITS];

  generate
    if (GHR_BITS == 1) begin : g_ghr_single
      assign ghr_next = executing_branch_taken;
    end else begin : g_ghr_shift
      assign ghr_next = {ghr_q[GHR_BITS-2:0], executing_branch_taken};
    end
  endgenerate

  // History only moves on resolution, so there is nothing to repair on a mispredict.
  always_ff @(posedge clock) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (do_update) begin
      ghr_q <= ghr_next;
    end
  end

  always_ff @(posedge clock) begin
    if (init_write_btb) begin
      btb[init_count_q[BTB_LOG_ENTRIES-1:0]] <= '0;
    end else if (do_update) begin
      btb[update_btb_index] <= btb_row_t'{valid: 1'b1,
                                          tag: update_tag,
                                          target: executing_branch_target};
    end
  end

  // The tag is compared after the register so the lookup path stays short.
  always_ff @(posedge clock) begin
    if (reset) begin
      pred_entry_q     <= '0;
      pred_tag_q       <= '0;
      pred_pht_index_q <= '0;
    end else if (advance) begin
      pred_entry_q     <= btb[fetch_btb_index];
      pred_tag_q       <= fetch_tag;
      pred_pht_index_q <= fetch_pht_index;
    end
  end

  pht_counter_table #(
    .LOG_ENTRIES (PHT_LOG_ENTRIES)
  ) u_pht (
    .clock        (clock),
    .reset        (reset),
    .init_write   (init_write_pht),
    .init_index   (init_count_q[PHT_LOG_ENTRIES-1:0]),
    .update_write (do_update),
    .update_index (executing_branch_pht_index),
    .update_taken (executing_branch_taken),
    .read_enable  (advance),
    .read_index   (fetch_pht_index),
    .read_counter (pred_counter)
  );

  assign ready                       = running;
  assign predicted_jump_target_taken = pred_entry_q.valid
                                       && (pred_entry_q.tag == pred_tag_q)
                                       && pred_counter[1];
  assign predicted_jump_target       = pred_entry_q.target;
  assign predicted_pht_index         = pred_pht_index_q;

  // PC offset bits and the counter's low bit do not feed any decision.
  assign unused_bits = ^{incoming_instruction_pc, executing_branch_pc, pred_counter};

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;
  import gshare_branch_predictor_pkg::*;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        ready;
  logic        executing_branch_active;
  logic [31:0] executing_branch_pc;
  logic [31:0] executing_branch_target;
  logic        executing_branch_taken;
  logic [9:0]  executing_branch_pht_index;
  logic [31:0] incoming_instruction_pc;
  logic        predicted_jump_target_taken;
  logic [31:0] predicted_jump_target;
  logic [9:0]  predicted_pht_index;

  gshare_branch_predictor dut (
    .clock                       (clock),
    .reset                       (reset),
    .enable                      (enable),
    .ready                       (ready),
    .executing_branch_active     (executing_branch_active),
    .executing_branch_pc         (executing_branch_pc),
    .executing_branch_target     (executing_branch_target),
    .executing_branch_taken      (executing_branch_taken),
    .executing_branch_pht_index  (executing_branch_pht_index),
    .incoming_instruction_pc     (incoming_instruction_pc),
    .predicted_jump_target_taken (predicted_jump_target_taken),
    .predicted_jump_target       (predicted_jump_target),
    .predicted_pht_index         (predicted_pht_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [9:0]  idx;
    logic        rdy;
  } exp_t;

  int total = 0;
  int bad   = 0;

  exp_t       sb[$];
  exp_t       last_pred;
  btb_entry_t m_btb [256];
  logic [1:0] m_pht [1024];
  logic [7:0] m_ghr;
  bit         m_run;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_cnt = 0;
    m_ghr = '0;
    last_pred = '0;
    for (int i = 0; i < 256; i++) m_btb[i] = '0;
    for (int i = 0; i < 1024; i++) m_pht[i] = 2'b01;
  endtask

  task automatic step(input logic rst, input logic en, input logic [31:0] fpc,
                      input logic ua, input logic [31:0] upc, input logic [31:0] utgt,
                      input logic utk, input logic [9:0] uidx);
    exp_t       e;
    btb_entry_t ent;
    logic [9:0] pidx;
    logic [1:0] c;
    @(negedge clock);
    reset                      = rst;
    enable                     = en;
    incoming_instruction_pc    = fpc;
    executing_branch_active    = ua;
    executing_branch_pc        = upc;
    executing_branch_target    = utgt;
    executing_branch_taken     = utk;
    executing_branch_pht_index = uidx;
    if (rst) begin
      model_reset();
    end else if (!m_run) begin
      if (m_cnt == 1023) m_run = 1'b1;
      else m_cnt++;
    end else if (en) begin
      ent  = m_btb[fpc[9:2]];
      pidx = fpc[11:2] ^ {2'b00, m_ghr};
      last_pred.taken  = ent.valid && (ent.tag == fpc[31:10]) && m_pht[pidx][1];
      last_pred.target = ent.target;
      last_pred.idx    = pidx;
      if (ua) begin
        m_btb[upc[9:2]] = '{valid: 1'b1, tag: upc[31:10], target: utgt};
        c = m_pht[uidx];
        if (utk && c != 2'b11) c = c + 2'b01;
        else if (!utk && c != 2'b00) c = c - 2'b01;
        m_pht[uidx] = c;
        m_ghr = {m_ghr[6:0], utk};
      end
    end
    e = last_pred;
    e.rdy = m_run;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("sb_taken",  {31'b0, predicted_jump_target_taken}, {31'b0, e.taken});
    check("sb_target", predicted_jump_target, e.target);
    check("sb_index",  {22'b0, predicted_pht_index}, {22'b0, e.idx});
    check("sb_ready",  {31'b0, ready}, {31'b0, e.rdy});
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(1'b0, 1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 10'h0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic [9:0] idx);
    step(1'b0, 1'b1, 32'h0, 1'b1, pc, tgt, tk, idx);
  endtask

  task automatic expect_pred(input string tag, input logic tk,
                             input logic [31:0] tgt, input logic [9:0] idx);
    check({tag, "_taken"},  {31'b0, predicted_jump_target_taken}, {31'b0, tk});
    check({tag, "_target"}, predicted_jump_target, tgt);
    check({tag, "_index"},  {22'b0, predicted_pht_index}, {22'b0, idx});
  endtask

  initial begin
    logic [9:0] ret_idx;
    reset = 1'b1;
    enable = 1'b0;
    incoming_instruction_pc = '0;
    executing_branch_active = 1'b0;
    executing_branch_pc = '0;
    executing_branch_target = '0;
    executing_branch_taken = 1'b0;
    executing_branch_pht_index = '0;
    model_reset();

    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 10'h0);
    step(1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 10'h0);
    check("reset_ready", {31'b0, ready}, 32'd0);

    // INIT with traffic that must be ignored; ready rises on the 1024th edge.
    for (int i = 0; i < 1024; i++) begin
      step(1'b0, i[0], 32'h100 + 32'(i) * 4, 1'b1, 32'h100, 32'hDEAD0000, 1'b1, i[9:0]);
      if (i == 1022) check("init_ready_low", {31'b0, ready}, 32'd0);
    end
    check("init_ready_high", {31'b0, ready}, 32'd1);

    // Basic training: GHR becomes 0b11, so the fetch lands on a fresh counter.
    train(32'h100, 32'h200, 1'b1, 10'h040);
    train(32'h100, 32'h200, 1'b1, 10'h040);
    fetch(32'h100);
    expect_pred("basic", 1'b0, 32'h200, 10'h043);

    // Loop branch trained with the indices the predictor hands back.
    for (int k = 0; k < 8; k++) begin
      fetch(32'h180);
      ret_idx = predicted_pht_index;
      train(32'h180, 32'h300, 1'b1, ret_idx);
    end
    fetch(32'h180);
    expect_pred("loop_sat", 1'b1, 32'h300, 10'h09F);
    train(32'h180, 32'h300, 1'b0, 10'h09F);
    for (int k = 0; k < 8; k++) train(32'h700, 32'h704, 1'b1, 10'h001);
    fetch(32'h180);
    expect_pred("loop_weak", 1'b1, 32'h300, 10'h09F);

    // Aliasing: same BTB slot, different tag, strong counter.
    train(32'h100, 32'h200, 1'b1, 10'h1BF);
    train(32'h100, 32'h200, 1'b1, 10'h1BF);
    fetch(32'h500);
    expect_pred("alias", 1'b0, 32'h200, 10'h1BF);

    // Stall with an active not-taken update that must be dropped.
    fetch(32'h180);
    expect_pred("pre_stall", 1'b1, 32'h300, 10'h09F);
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b0, 32'h500, 1'b1, 32'h180, 32'h999, 1'b0, 10'h09F);
    expect_pred("stall_hold", 1'b1, 32'h300, 10'h09F);
    fetch(32'h180);
    expect_pred("post_stall", 1'b1, 32'h300, 10'h09F);

    // Reset mid-RUN, then again mid-INIT; tables and GHR must start over.
    step(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 10'h0);
    check("rst_run_ready", {31'b0, ready}, 32'd0);
    expect_pred("rst_run", 1'b0, 32'h0, 10'h0);
    for (int i = 0; i < 100; i++) fetch(32'h100);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 10'h0);
    for (int i = 0; i < 1024; i++) fetch(32'h100);
    check("reinit_ready", {31'b0, ready}, 32'd1);
    fetch(32'h100);
    expect_pred("after_reinit", 1'b0, 32'h0, 10'h040);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
